// File: rtl/cpu_ctrl_pkg.sv
// Shared control package for the ALU instruction sequencer.
// Holds the opcode/ALU codes, the state encoding and the IR field positions.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_SHL  = 5'd5;
  localparam logic [4:0] OP_SHRA = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_MUL  = 5'd9;
  localparam logic [4:0] OP_DIV  = 5'd10;
  localparam logic [4:0] OP_NEG  = 5'd11;
  localparam logic [4:0] OP_NOT  = 5'd12;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SHR  = 4'd4;
  localparam logic [3:0] ALU_SHL  = 4'd5;
  localparam logic [3:0] ALU_SHRA = 4'd6;
  localparam logic [3:0] ALU_ROR  = 4'd7;
  localparam logic [3:0] ALU_ROL  = 4'd8;
  localparam logic [3:0] ALU_MUL  = 4'd9;
  localparam logic [3:0] ALU_DIV  = 4'd10;
  localparam logic [3:0] ALU_NEG  = 4'd11;
  localparam logic [3:0] ALU_NOT  = 4'd12;

  localparam int OPC_LSB = 27;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2,
    S_T3, S_T4, S_T5, S_T6
  } state_t;

  function automatic logic op_legal(input logic [4:0] op);
    return op <= OP_NOT;
  endfunction

  function automatic logic op_unary(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic op_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic [3:0] op_to_alu(input logic [4:0] op);
    logic [3:0] a;
    case (op)
      OP_ADD:  a = ALU_ADD;
      OP_SUB:  a = ALU_SUB;
      OP_AND:  a = ALU_AND;
      OP_OR:   a = ALU_OR;
      OP_SHR:  a = ALU_SHR;
      OP_SHL:  a = ALU_SHL;
      OP_SHRA: a = ALU_SHRA;
      OP_ROR:  a = ALU_ROR;
      OP_ROL:  a = ALU_ROL;
      OP_MUL:  a = ALU_MUL;
      OP_DIV:  a = ALU_DIV;
      OP_NEG:  a = ALU_NEG;
      OP_NOT:  a = ALU_NOT;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/reg_onehot_decode.sv
// Register number to one-hot enable vector.
// Produces all zeros when disabled or when the index is out of range.
module reg_onehot_decode #(
  parameter int NREGS = 16
) (
  input  logic [3:0]       i_idx,
  input  logic             i_en,
  output logic [NREGS-1:0] o_vec
);

  // one-hot decode of the selected register
  always_comb begin
    o_vec = '0;
    if (i_en && (32'(i_idx) < NREGS))
      o_vec[i_idx] = 1'b1;
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Fetch/execute control sequencer for one register-register ALU instruction.
// Outputs decode from state, the first-T1 flag and the ir fields.
module alu_instr_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             mem_ready,
  input  logic [31:0]      ir,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Zlowin,
  output logic             Zhighin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             LOin,
  output logic             HIin,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic [3:0]       ALUop,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  state_t     r_state;
  logic       r_first;
  logic [4:0] r_op;
  logic [3:0] r_ra;
  logic [3:0] r_rb;
  logic [3:0] r_rc;

  logic [4:0] w_ir_op;
  logic [3:0] w_ir_ra;
  logic [3:0] w_ir_rb;
  logic [3:0] w_ir_rc;
  logic       w_unused;
  logic       w_rout_en;
  logic [3:0] w_rout_idx;
  logic       w_rin_en;

  assign w_ir_op  = ir[OPC_LSB +: 5];
  assign w_ir_ra  = ir[RA_LSB +: 4];
  assign w_ir_rb  = ir[RB_LSB +: 4];
  assign w_ir_rc  = ir[RC_LSB +: 4];
  assign w_unused = ^ir[RC_LSB-1:0];

  assign busy = (r_state != S_IDLE);

  // state register; fields are captured as T3 is left
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
      r_first <= 1'b0;
      r_op    <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rc    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (start) r_state <= S_T0;
        S_T0: begin
          r_state <= S_T1;
          r_first <= 1'b1;
        end
        S_T1: begin
          r_first <= 1'b0;
          if (mem_ready) r_state <= S_T2;
        end
        S_T2: r_state <= S_T3;
        S_T3: begin
          r_op    <= w_ir_op;
          r_ra    <= w_ir_ra;
          r_rb    <= w_ir_rb;
          r_rc    <= w_ir_rc;
          r_state <= op_legal(w_ir_op) ? S_T4 : S_IDLE;
        end
        S_T4: r_state <= S_T5;
        S_T5: r_state <= op_muldiv(r_op) ? S_T6 : S_IDLE;
        S_T6: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Moore strobe decode
  always_comb begin
    {PCout, MARin, IncPC, PCin, Read} = '0;
    {MDRin, MDRout, IRin, Yin} = '0;
    {Zlowin, Zhighin, Zlowout} = '0;
    {Zhighout, LOin, HIin} = '0;
    ALUop      = '0;
    done       = 1'b0;
    illegal    = 1'b0;
    w_rout_en  = 1'b0;
    w_rout_idx = r_rc;
    w_rin_en   = 1'b0;
    unique case (r_state)
      S_IDLE: ;
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        if (r_first) begin
          Zlowout = 1'b1;
          PCin    = 1'b1;
        end
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (op_legal(w_ir_op)) begin
          Yin        = 1'b1;
          w_rout_en  = 1'b1;
          w_rout_idx = w_ir_rb;
        end else begin
          illegal = 1'b1;
        end
      end
      S_T4: begin
        Zlowin     = 1'b1;
        Zhighin    = op_muldiv(r_op);
        ALUop      = op_to_alu(r_op);
        w_rout_en  = 1'b1;
        w_rout_idx = op_unary(r_op) ? r_rb : r_rc;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (op_muldiv(r_op)) begin
          LOin = 1'b1;
        end else begin
          w_rin_en = 1'b1;
          done     = 1'b1;
        end
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  reg_onehot_decode #(.NREGS(NREGS)) u_rin (
    .i_idx (r_ra),
    .i_en  (w_rin_en),
    .o_vec (Rin)
  );

  reg_onehot_decode #(.NREGS(NREGS)) u_rout (
    .i_idx (w_rout_idx),
    .i_en  (w_rout_en),
    .o_vec (Rout)
  );

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Scoreboard bench for alu_instr_sequencer.
// Expected per-cycle strobe rows are queued by stimulus, popped by a monitor.
module tb_alu_instr_sequencer;

  localparam logic [14:0] PCO = 15'h4000;
  localparam logic [14:0] MAR = 15'h2000;
  localparam logic [14:0] INC = 15'h1000;
  localparam logic [14:0] PCI = 15'h0800;
  localparam logic [14:0] RD  = 15'h0400;
  localparam logic [14:0] MDI = 15'h0200;
  localparam logic [14:0] MDO = 15'h0100;
  localparam logic [14:0] IRI = 15'h0080;
  localparam logic [14:0] YIN = 15'h0040;
  localparam logic [14:0] ZLI = 15'h0020;
  localparam logic [14:0] ZHI = 15'h0010;
  localparam logic [14:0] ZLO = 15'h0008;
  localparam logic [14:0] ZHO = 15'h0004;
  localparam logic [14:0] LOI = 15'h0002;
  localparam logic [14:0] HII = 15'h0001;

  typedef struct {
    logic [52:0] v;
    string       tag;
  } exp_t;

  logic        clk;
  logic        clear;
  logic        start;
  logic        mem_ready;
  logic [31:0] ir_q = 32'h0;
  logic PCout, MARin, IncPC, PCin, Read;
  logic MDRin, MDRout, IRin, Yin;
  logic Zlowin, Zhighin, Zlowout;
  logic Zhighout, LOin, HIin;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic [3:0]  ALUop;
  logic busy, done, illegal;

  exp_t        q[$];
  int          eq[$];
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  logic [31:0] prog;
  int          wait_cfg;
  int          wait_left = 0;
  bit          scramble;
  int          sc;

  alu_instr_sequencer #(.NREGS(16)) dut (
    .clock    (clk),
    .clear    (clear),
    .start    (start),
    .mem_ready(mem_ready),
    .ir       (ir_q),
    .PCout    (PCout),
    .MARin    (MARin),
    .IncPC    (IncPC),
    .PCin     (PCin),
    .Read     (Read),
    .MDRin    (MDRin),
    .MDRout   (MDRout),
    .IRin     (IRin),
    .Yin      (Yin),
    .Zlowin   (Zlowin),
    .Zhighin  (Zhighin),
    .Zlowout  (Zlowout),
    .Zhighout (Zhighout),
    .LOin     (LOin),
    .HIin     (HIin),
    .Rin      (Rin),
    .Rout     (Rout),
    .ALUop    (ALUop),
    .busy     (busy),
    .done     (done),
    .illegal  (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // IR register of the datapath; optionally trashed during T4
  always @(clk) begin
    if (clk) begin
      if (IRin) ir_q <= prog;
    end else if (scramble && Zlowin && !PCout) begin
      ir_q <= 32'hFFFF_FFFF;
    end
  end

  // memory: hold mem_ready low for wait_cfg T1 cycles
  always @(negedge clk) begin
    if (Read) begin
      if (wait_left > 0) begin
        mem_ready = 1'b0;
        wait_left = wait_left - 1;
      end else begin
        mem_ready = 1'b1;
      end
    end else begin
      wait_left = wait_cfg;
      mem_ready = (wait_cfg == 0);
    end
  end

  function automatic logic [52:0] obs();
    return {PCout, MARin, IncPC, PCin, Read,
            MDRin, MDRout, IRin, Yin,
            Zlowin, Zhighin, Zlowout,
            Zhighout, LOin, HIin,
            Rin, Rout, ALUop, done, illegal};
  endfunction

  function automatic logic [52:0] row(
    input logic [14:0] s, input logic [15:0] rin,
    input logic [15:0] rout, input logic [3:0] a,
    input logic d, input logic il);
    return {s, rin, rout, a, d, il};
  endfunction

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // monitor: reset, idle and per-state scoreboard comparisons
  always @(negedge clk or negedge clear) begin
    if (!clear) begin
      #1;
      check("reset_out", 64'(obs()), 64'h0);
      check("reset_busy", 64'(busy), 64'h0);
    end else if (busy) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_busy got=%h want=idle", obs());
      end else begin
        exp_t e;
        e = q.pop_front();
        check(e.tag, 64'(obs()), 64'(e.v));
      end
      if (done || illegal) begin
        if (eq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_end got=cyc%0d want=none", cyc);
        end else begin
          check("latency", 64'(cyc), 64'(eq.pop_front()));
        end
      end
    end else begin
      check("idle", 64'(obs()), 64'h0);
    end
  end

  task automatic push(input logic [52:0] v, input string t);
    exp_t e;
    e.v = v;
    e.tag = t;
    q.push_back(e);
  endtask

  task automatic push_fetch(input string t, input int k);
    push(row(PCO | MAR | INC | ZLI, 0, 0, 0, 0, 0), {t, ".T0"});
    push(row(ZLO | PCI | RD | MDI, 0, 0, 0, 0, 0), {t, ".T1"});
    for (int i = 0; i < k; i++)
      push(row(RD | MDI, 0, 0, 0, 0, 0), {t, ".T1w"});
    push(row(MDO | IRI, 0, 0, 0, 0, 0), {t, ".T2"});
  endtask

  task automatic go(input logic [31:0] w, input int k,
                    input bit hold, output int s);
    @(negedge clk);
    #2;
    prog = w;
    wait_cfg = k;
    start = 1'b1;
    @(posedge clk);
    #1;
    s = cyc;
    if (!hold) start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || eq.size() != 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() != 0 || eq.size() != 0) begin
      $display("FAIL drain_timeout rows=%0d evts=%0d want=0",
               q.size(), eq.size());
      $fatal(1, "sequencer stalled");
    end
  endtask

  initial begin
    clear = 1'b0;
    start = 1'b0;
    prog = 32'h0;
    wait_cfg = 0;
    scramble = 1'b0;
    repeat (3) @(negedge clk);
    #2 clear = 1'b1;

    // SHRA R7 = R0 >>> R4
    push_fetch("shra", 0);
    push(row(YIN, 0, 16'h0001, 0, 0, 0), "shra.T3");
    push(row(ZLI, 0, 16'h0010, 4'd6, 0, 0), "shra.T4");
    push(row(ZLO, 16'h0080, 0, 0, 1, 0), "shra.T5");
    go(32'h3382_0000, 0, 1'b0, sc);
    eq.push_back(sc + 5);
    drain(30);

    // MUL R3 * R5 with two memory wait cycles
    push_fetch("mul", 2);
    push(row(YIN, 0, 16'h0008, 0, 0, 0), "mul.T3");
    push(row(ZLI | ZHI, 0, 16'h0020, 4'd9, 0, 0), "mul.T4");
    push(row(ZLO | LOI, 0, 0, 0, 0, 0), "mul.T5");
    push(row(ZHO | HII, 0, 0, 0, 1, 0), "mul.T6");
    go(32'h489A_8000, 2, 1'b0, sc);
    eq.push_back(sc + 8);
    drain(30);

    // illegal opcode 20
    push_fetch("ill", 0);
    push(row(0, 0, 0, 0, 0, 1), "ill.T3");
    go(32'hA091_8000, 0, 1'b0, sc);
    eq.push_back(sc + 3);
    drain(30);

    // ADD aborted by reset in T4
    push_fetch("rst", 0);
    push(row(YIN, 0, 16'h0002, 0, 0, 0), "rst.T3");
    push(row(ZLI, 0, 16'h0004, 4'd0, 0, 0), "rst.T4");
    go(32'h0289_0000, 0, 1'b0, sc);
    drain(30);
    #1 clear = 1'b0;
    #2 clear = 1'b1;
    repeat (3) @(negedge clk);

    // two back-to-back NOTs, ir trashed after T3
    scramble = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_fetch("not", 0);
      push(row(YIN, 0, 16'h8000, 0, 0, 0), "not.T3");
      push(row(ZLI, 0, 16'h8000, 4'd12, 0, 0), "not.T4");
      push(row(ZLO, 16'h0004, 0, 0, 1, 0), "not.T5");
    end
    go(32'h6179_8000, 0, 1'b1, sc);
    eq.push_back(sc + 5);
    eq.push_back(sc + 12);
    drain(40);
    start = 1'b0;
    scramble = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
